// File: rtl/mod_n_classifier.sv
// Bit-serial MSB-first remainder classifier: reports data mod MODULUS plus even/odd flags.
// Optional saturating even/odd result counters are built when MODCLS_STATS_EN is defined.
module mod_n_classifier #(
  parameter int DATA_W  = 8,
  parameter int MODULUS = 3,
  parameter int CNT_W   = 16,
  localparam int RW     = ($clog2(MODULUS) < 1) ? 1 : $clog2(MODULUS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              even,
  output logic              odd,
  output logic              divisible,
  output logic [RW-1:0]     remainder,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  even_cnt,
  output logic [CNT_W-1:0]  odd_cnt
);

  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q;
  logic [RW-1:0]     r_q, r_d;
  logic [RW:0]       r_wide;
  logic [CW-1:0]     cnt_q;
  logic              even_q, odd_q, div_q;
  logic [RW-1:0]     rem_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)      state_d = CALC;
      CALC:    if (cnt_q == '0)   state_d = DONE;
      DONE:    if (out_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // 2r+msb is below 2*MODULUS, so a single conditional subtract keeps r reduced.
  always_comb begin
    r_wide = {r_q, shreg_q[DATA_W-1]};
    r_d    = r_wide[RW-1:0];
    if (r_wide >= (RW+1)'(MODULUS)) r_d = RW'(r_wide - (RW+1)'(MODULUS));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      div_q   <= 1'b0;
      even_q  <= 1'b0;
      odd_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          shreg_q <= data_in;
          r_q     <= '0;
          cnt_q   <= CW'(DATA_W-1);
        end
        CALC: begin
          shreg_q <= shreg_q << 1;
          r_q     <= r_d;
          cnt_q   <= cnt_q - 1'b1;
          // On the final step the shifted-out MSB is the original LSB.
          if (cnt_q == '0) begin
            rem_q  <= r_d;
            div_q  <= (r_d == '0);
            even_q <= ~shreg_q[DATA_W-1];
            odd_q  <= shreg_q[DATA_W-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign remainder = rem_q;
  assign divisible = div_q;
  assign even      = even_q;
  assign odd       = odd_q;

`ifdef MODCLS_STATS_EN
  logic [CNT_W-1:0] even_cnt_q, odd_cnt_q;
  logic             hs;
  assign hs = out_valid & out_ready;

  // Clear takes priority over a coincident handshake increment.
  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      even_cnt_q <= '0;
      odd_cnt_q  <= '0;
    end else if (hs) begin
      if (even_q && !(&even_cnt_q)) even_cnt_q <= even_cnt_q + 1'b1;
      if (odd_q  && !(&odd_cnt_q))  odd_cnt_q  <= odd_cnt_q + 1'b1;
    end
  end

  assign even_cnt = even_cnt_q;
  assign odd_cnt  = odd_cnt_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign even_cnt = '0;
  assign odd_cnt  = '0;
`endif

endmodule

// File: tb/tb_mod_n_classifier.sv
module tb_mod_n_classifier;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset, in_valid, out_ready, stats_clr;
  logic [DW-1:0] data_in;

  logic          in_ready3, out_valid3, even3, odd3, div3;
  logic [1:0]    rem3;
  logic [15:0]   ec3, oc3;
  logic          in_ready5, out_valid5, even5, odd5, div5;
  logic [2:0]    rem5;
  logic [1:0]    ec5, oc5;

  int total = 0, bad = 0;
  int e3 = 0, o3 = 0, e5 = 0, o5 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  mod_n_classifier #(.DATA_W(DW), .MODULUS(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
    .data_in(data_in), .out_valid(out_valid3), .out_ready(out_ready),
    .even(even3), .odd(odd3), .divisible(div3), .remainder(rem3),
    .stats_clr(stats_clr), .even_cnt(ec3), .odd_cnt(oc3));

  mod_n_classifier #(.DATA_W(DW), .MODULUS(5), .CNT_W(2)) dut5 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready5),
    .data_in(data_in), .out_valid(out_valid5), .out_ready(out_ready),
    .even(even5), .odd(odd5), .divisible(div5), .remainder(rem5),
    .stats_clr(stats_clr), .even_cnt(ec5), .odd_cnt(oc5));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int exp_cnt(input int m);
`ifdef MODCLS_STATS_EN
    return m;
`else
    return 0;
`endif
  endfunction

  task automatic check_counters();
    chk("even_cnt3", int'(ec3), exp_cnt(e3));
    chk("odd_cnt3",  int'(oc3), exp_cnt(o3));
    chk("even_cnt5", int'(ec5), exp_cnt(e5));
    chk("odd_cnt5",  int'(oc5), exp_cnt(o5));
  endtask

  task automatic check_reset_state();
    chk("rst_in_ready", {in_ready3, in_ready5}, 2'b11);
    chk("rst_out_valid", {out_valid3, out_valid5}, 2'b00);
    chk("rst_flags", {even3, odd3, div3, even5, odd5, div5}, 6'b0);
    chk("rst_rem", {rem3, rem5}, 5'b0);
    check_counters();
  endtask

  task automatic check_results(input logic [DW-1:0] d);
    int v;
    v = int'(d);
    chk("out_valid", {out_valid3, out_valid5}, 2'b11);
    chk("rem3", int'(rem3), v % 3);
    chk("div3", div3, 1'((v % 3) == 0));
    chk("rem5", int'(rem5), v % 5);
    chk("div5", div5, 1'((v % 5) == 0));
    chk("even", {even3, even5}, {2{~d[0]}});
    chk("odd",  {odd3, odd5}, {2{d[0]}});
  endtask

  task automatic update_model(input logic [DW-1:0] d, input bit clr);
    if (clr) begin
      e3 = 0; o3 = 0; e5 = 0; o5 = 0;
    end else if (d[0]) begin
      if (o3 < 65535) o3++;
      if (o5 < 3) o5++;
    end else begin
      if (e3 < 65535) e3++;
      if (e5 < 3) e5++;
    end
  endtask

  task automatic handshake(input logic [DW-1:0] d, input bit clr);
    out_ready = 1'b1; stats_clr = clr;
    tick();
    out_ready = 1'b0; stats_clr = 1'b0;
    update_model(d, clr);
    chk("post_hs_valid", {out_valid3, out_valid5}, 2'b00);
    chk("post_hs_ready", {in_ready3, in_ready5}, 2'b11);
    check_counters();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!out_valid3 && n < 40) begin
      tick();
      n++;
    end
    chk("latency", n, DW);
  endtask

  task automatic send(input logic [DW-1:0] d);
    int n;
    n = 0;
    while (!in_ready3 && n < 40) begin
      tick();
      n++;
    end
    chk("send_wait", (n < 40), 1'b1);
    in_valid = 1'b1; data_in = d;
    tick();
    in_valid = 1'b0;
    chk("accepted", {in_ready3, in_ready5}, 2'b00);
  endtask

  task automatic full(input logic [DW-1:0] d, input bit clr);
    send(d);
    wait_done();
    check_results(d);
    handshake(d, clr);
  endtask

  initial begin
    logic [DW-1:0] d;
    bit seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; stats_clr = 1'b0; data_in = '0;
    tick(); tick();
    check_reset_state();
    reset = 1'b0;
    tick();

    full(8'h2A, 1'b0);

    in_valid = 1'b1; data_in = 8'h07;
    tick();
    data_in = 8'hFF;
    wait_done();
    check_results(8'h07);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    update_model(8'h07, 1'b0);
    chk("b2b_idle", in_ready3, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("b2b_accept", in_ready3, 1'b0);
    wait_done();
    check_results(8'hFF);
    handshake(8'hFF, 1'b0);

    send(8'h2B);
    wait_done();
    in_valid = 1'b1; data_in = 8'h10;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ready", {in_ready3, in_ready5}, 2'b00);
      check_results(8'h2B);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    update_model(8'h2B, 1'b0);
    chk("bp_idle", in_ready3, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("bp_accept", in_ready3, 1'b0);
    wait_done();
    check_results(8'h10);
    handshake(8'h10, 1'b0);

    send(8'h55);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    e3 = 0; o3 = 0; e5 = 0; o5 = 0;
    check_reset_state();
    seen = 1'b0;
    for (int i = 0; i < DW + 2; i++) begin
      tick();
      if (out_valid3 || out_valid5) seen = 1'b1;
    end
    chk("no_valid_after_rst", seen, 1'b0);

    full(8'h00, 1'b0);
    full(8'hC8, 1'b0);
    full(8'hFE, 1'b0);

    for (int i = 0; i < 5; i++) full(8'(2 * i + 4), 1'b0);
    full(8'h33, 1'b1);

    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      send(d);
      wait_done();
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
      check_results(d);
      handshake(d, ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_n_classifier.md
Name: mod_n_classifier

Overview:
- Parametrised successor to the even/odd classifier.
- Accepts one DATA_W-bit sample per valid/ready handshake and runs a remainder state machine over its bits, MSB first, one bit per cycle.
- Reports the sample's remainder modulo MODULUS, a divisible flag and even/odd flags through an output valid/ready handshake.
- Sits between a sample producer and a downstream consumer/statistics unit. Optional saturating even/odd counters are included.

Parameters:
- DATA_W, 8, sample width in bits (>=2).
- MODULUS, 3, divisor (2..2^DATA_W-1).
- CNT_W, 16, width of the statistics counters.
- RW (localparam), max(1, $clog2(MODULUS)), remainder width.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  sample present on data_in.
- in_ready  out  1  block can accept a sample.
- data_in  in  DATA_W  sample value, unsigned.
- out_valid  out  1  result outputs valid.
- out_ready  in  1  consumer takes the result.
- even  out  1  sample LSB = 0.
- odd  out  1  sample LSB = 1.
- divisible  out  1  remainder == 0.
- remainder  out  RW  sample mod MODULUS.
- stats_clr  in  1  clear counters (only with MODCLS_STATS_EN).
- even_cnt  out  CNT_W  count of even results delivered.
- odd_cnt  out  CNT_W  count of odd results delivered.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled only on the rising edge of clk; there is no asynchronous path.
- Reset values: state IDLE, out_valid 0, even 0, odd 0, divisible 0, remainder 0, even_cnt/odd_cnt 0, in_ready 1 once reset has been sampled.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - CALC: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- in_ready and out_valid are decoded directly from state; no combinational path from in_valid or out_ready.
- IDLE -> CALC: on an edge with in_valid=1. Latch data_in into a shift register, clear the working remainder to 0, load the bit counter with DATA_W-1.
- CALC, each edge:
  - r_next = 2*r + msb. Since r < MODULUS, r_next < 2*MODULUS, so apply one conditional subtract of MODULUS.
  - Shift the register left and decrement the counter.
  - Working remainder width is RW+1 bits internally.
- CALC -> DONE: on the edge that processes bit 0. On that same edge register:
  - remainder = final r
  - divisible = (final r == 0)
  - even = ~latched_bit0
  - odd = latched_bit0
- Latency: out_valid rises exactly DATA_W cycles after the accept edge.
- DONE -> IDLE: on an edge with out_ready=1. A new sample can be accepted on the following edge. Maximum throughput is one sample per DATA_W+2 cycles.
- Output holding:
  - While in DONE with out_ready=0, all result outputs hold stable indefinitely.
  - After the handshake, result outputs keep their last values; they are meaningful only while out_valid=1.
- in_valid while in CALC or DONE is ignored; no sample is lost silently, because in_ready=0 there.
- Reset mid-CALC or mid-DONE: return to IDLE on that edge. The in-flight sample is discarded, with no out_valid pulse, and all outputs take their reset values.
- even and odd are never both 1. Both are 0 only after reset, before the first result.

Optional Feature:
- Macro: MODCLS_STATS_EN.
- Defined:
  - even_cnt/odd_cnt increment by 1 on each output handshake (out_valid & out_ready) for an even/odd result respectively.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
  - stats_clr=1 zeroes both counters on that edge; clear wins over a simultaneous increment.
  - reset also zeroes both counters.
- Not defined: even_cnt/odd_cnt are tied to 0, stats_clr is ignored, and no counter flops are inferred. Ports remain present in both builds.

Test Plan:
- DATA_W=8, MODULUS=3; send 0x2A (42) -> out_valid 8 cycles after the accept edge; remainder=0, divisible=1, even=1, odd=0.
- Send 0x07, then 0xFF back-to-back with in_valid held high -> remainder=1, odd=1 for 0x07; then remainder=0, divisible=1, odd=1 for 0xFF. Second accept occurs exactly one cycle after the first handshake.
- Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 with 0x10 -> outputs stable, in_ready=0, 0x10 accepted only after the handshake; its result is remainder=1, even=1.
- Reset asserted at CALC cycle 4 of sample 0x55 -> next cycle IDLE, in_ready=1, no out_valid for 0x55, all outputs at reset values.
- MODULUS=5 build; send 0x00 and 0xC8 (200) -> both give remainder=0, divisible=1, even=1. Send 0xFE (254) -> remainder=4, divisible=0.
- MODCLS_STATS_EN, CNT_W=2: five even results -> even_cnt saturates at 3. Then stats_clr coincident with an odd handshake -> both counters 0.
